// File: rtl/door_lock_keypad_ctrl.sv
// Purpose : keypad front-end for door_lock_FSM; buffers hex digits, submits code, runs unlock/lockout timers.
// Latency : o_confirm one cycle after enter; verdict window counts from the confirm strobe (RESP_TIMEOUT cycles).
// Backpressure: none; key strobes arriving while busy (CONFIRM/WAIT_RESP/UNLOCKED/LOCKOUT) are dropped.
module door_lock_keypad_ctrl #(
    parameter int DIGITS         = 3,
    parameter int ENTRY_TIMEOUT  = 1000,
    parameter int RESP_TIMEOUT   = 8,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int LOCKOUT_CYCLES = 2000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_key_valid,
    input  logic [3:0]            i_key_code,
    input  logic                  i_key_enter,
    input  logic                  i_key_clear,
    input  logic                  i_correct,
    input  logic                  i_incorrect,
    input  logic [1:0]            i_trials,
    output logic [4*DIGITS-1:0]   o_password,
    output logic                  o_confirm,
    output logic                  o_unlock,
    output logic                  o_busy,
    output logic                  o_error,
    output logic [1:0]            o_digit_cnt,
    output logic [2:0]            o_state
);

    localparam int PW_W   = 4 * DIGITS;
    localparam int T_A    = (ENTRY_TIMEOUT > RESP_TIMEOUT) ? ENTRY_TIMEOUT : RESP_TIMEOUT;
    localparam int T_B    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX  = (T_A > T_B) ? T_A : T_B;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Each timer load is "cycles - 1": the state exits on the cycle the counter reads zero.
    localparam logic [TW-1:0] ENTRY_LOAD  = TW'(ENTRY_TIMEOUT - 1);
    // The CONFIRM cycle is the first cycle of the verdict window, so WAIT_RESP holds one fewer.
    localparam logic [TW-1:0] RESP_LOAD   = TW'(RESP_TIMEOUT - 2);
    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    DIG_N       = 2'(DIGITS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENTRY     = 3'd1,
        S_CONFIRM   = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_UNLOCKED  = 3'd4,
        S_LOCKOUT   = 3'd5
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;

    assign o_state = state;

    // Busy covers every state in which digit/enter strobes are ignored.
    assign o_busy = (state == S_CONFIRM) || (state == S_WAIT_RESP) ||
                    (state == S_UNLOCKED) || (state == S_LOCKOUT);

    // Main sequencer: digit buffer, submit handshake, verdict handling and shared down-counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            o_password  <= '0;
            o_digit_cnt <= '0;
            o_confirm   <= 1'b0;
            o_unlock    <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_confirm <= 1'b0;
            o_error   <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (i_key_clear) begin
                        o_password  <= '0;
                        o_digit_cnt <= '0;
                        timer       <= '0;
                        state       <= S_IDLE;
                    end else if (i_key_enter) begin
                        timer <= '0;
                        if (o_digit_cnt == DIG_N) begin
                            o_confirm <= 1'b1;
                            state     <= S_CONFIRM;
                        end else begin
                            // Short entry: discard and flag it.
                            o_password  <= '0;
                            o_digit_cnt <= '0;
                            o_error     <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else if (i_key_valid) begin
                        // Extra digits past a full buffer are dropped but still keep the entry alive.
                        if (o_digit_cnt != DIG_N) begin
                            o_password  <= {o_password[PW_W-5:0], i_key_code};
                            o_digit_cnt <= o_digit_cnt + 2'd1;
                        end
                        timer <= ENTRY_LOAD;
                        state <= S_ENTRY;
                    end else if (state == S_ENTRY) begin
                        if (timer == '0) begin
                            // Abandoned entry: silently discard.
                            o_password  <= '0;
                            o_digit_cnt <= '0;
                            state       <= S_IDLE;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end

                S_CONFIRM: begin
                    timer <= RESP_LOAD;
                    state <= S_WAIT_RESP;
                end

                S_WAIT_RESP: begin
                    if (i_incorrect) begin
                        // Incorrect wins over a simultaneous correct.
                        o_password  <= '0;
                        o_digit_cnt <= '0;
                        if (i_trials == 2'd0) begin
                            timer <= LOCK_LOAD;
                            state <= S_LOCKOUT;
                        end else begin
                            timer <= '0;
                            state <= S_IDLE;
                        end
                    end else if (i_correct) begin
                        o_password  <= '0;
                        o_digit_cnt <= '0;
                        o_unlock    <= 1'b1;
                        timer       <= UNLOCK_LOAD;
                        state       <= S_UNLOCKED;
                    end else if (timer == '0) begin
                        o_password  <= '0;
                        o_digit_cnt <= '0;
                        o_error     <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_UNLOCKED: begin
                    if (i_key_clear || (timer == '0)) begin
                        o_unlock <= 1'b0;
                        timer    <= '0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_LOCKOUT: begin
                    // All keypad inputs, clear included, are ignored here.
                    if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    o_unlock <= 1'b0;
                    timer    <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_lock_keypad_ctrl.sv
// Purpose : self-checking bench for door_lock_keypad_ctrl (directed scenarios + random transactions).
// Latency : outputs sampled 1 time unit after each rising edge; inputs driven right after sampling.
// Backpressure: n/a.
module tb_door_lock_keypad_ctrl;

    localparam int DIGITS   = 3;
    localparam int ENTRY_T  = 16;
    localparam int RESP_T   = 4;
    localparam int UNLOCK_T = 8;
    localparam int LOCK_T   = 20;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_key_valid;
    logic [3:0]  i_key_code;
    logic        i_key_enter;
    logic        i_key_clear;
    logic        i_correct;
    logic        i_incorrect;
    logic [1:0]  i_trials;
    logic [11:0] o_password;
    logic        o_confirm;
    logic        o_unlock;
    logic        o_busy;
    logic        o_error;
    logic [1:0]  o_digit_cnt;
    logic [2:0]  o_state;

    door_lock_keypad_ctrl #(
        .DIGITS         (DIGITS),
        .ENTRY_TIMEOUT  (ENTRY_T),
        .RESP_TIMEOUT   (RESP_T),
        .UNLOCK_CYCLES  (UNLOCK_T),
        .LOCKOUT_CYCLES (LOCK_T)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_key_valid (i_key_valid),
        .i_key_code  (i_key_code),
        .i_key_enter (i_key_enter),
        .i_key_clear (i_key_clear),
        .i_correct   (i_correct),
        .i_incorrect (i_incorrect),
        .i_trials    (i_trials),
        .o_password  (o_password),
        .o_confirm   (o_confirm),
        .o_unlock    (o_unlock),
        .o_busy      (o_busy),
        .o_error     (o_error),
        .o_digit_cnt (o_digit_cnt),
        .o_state     (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_conf, n_err, n_unl, n_lock, conf_cyc, err_cyc;
    logic [11:0] pw_at_conf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample outputs away from the edge, accumulating event counts.
    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_confirm) begin
            n_conf++;
            conf_cyc   = cyc;
            pw_at_conf = o_password;
        end
        if (o_error) begin
            n_err++;
            err_cyc = cyc;
        end
        if (o_unlock) n_unl++;
        if (o_state == 3'd5) n_lock++;
    endtask

    task automatic clear_counts();
        n_conf = 0; n_err = 0; n_unl = 0; n_lock = 0;
        conf_cyc = 0; err_cyc = 0; pw_at_conf = '0;
    endtask

    task automatic press(input logic [3:0] code);
        i_key_valid = 1'b1;
        i_key_code  = code;
        tick();
        i_key_valid = 1'b0;
        i_key_code  = 4'h0;
    endtask

    task automatic enter();
        i_key_enter = 1'b1;
        tick();
        i_key_enter = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({o_password, o_confirm, o_unlock, o_busy, o_error, o_digit_cnt, o_state}), 32'd0);
    endtask

    // Random-transaction reference model variables
    int k, dl, v, t;
    int d [5];
    int exp_conf, exp_err, exp_unl, exp_lock, exp_pw;

    initial begin
        i_reset_n   = 1'b0;
        i_key_valid = 1'b0;
        i_key_code  = 4'h0;
        i_key_enter = 1'b0;
        i_key_clear = 1'b0;
        i_correct   = 1'b0;
        i_incorrect = 1'b0;
        i_trials    = 2'd0;
        clear_counts();

        // Reset state
        tick(); tick();
        chk_all_zero("reset_outputs");
        i_reset_n = 1'b1;
        tick();
        chk("reset_state_idle", 32'(o_state), 32'd0);

        // 1: B,A,D -> confirm 12'hBAD, correct two cycles later, 8 unlock cycles
        clear_counts();
        press(4'hB); press(4'hA); press(4'hD);
        chk("t1_pw", 32'(o_password), 32'hBAD);
        chk("t1_cnt", 32'(o_digit_cnt), 32'd3);
        chk("t1_state_entry", 32'(o_state), 32'd1);
        enter();
        chk("t1_confirm", 32'(o_confirm), 32'd1);
        chk("t1_state_confirm", 32'(o_state), 32'd2);
        chk("t1_busy", 32'(o_busy), 32'd1);
        tick();
        chk("t1_confirm_one_cycle", 32'(o_confirm), 32'd0);
        chk("t1_pw_held", 32'(o_password), 32'hBAD);
        chk("t1_state_wait", 32'(o_state), 32'd3);
        tick();
        i_correct = 1'b1; tick(); i_correct = 1'b0;
        chk("t1_unlock_rise", 32'(o_unlock), 32'd1);
        chk("t1_state_unlocked", 32'(o_state), 32'd4);
        repeat (11) tick();
        chk("t1_unlock_len", 32'(n_unl), 32'(UNLOCK_T));
        chk("t1_state_idle", 32'(o_state), 32'd0);
        chk("t1_conf_count", 32'(n_conf), 32'd1);
        chk("t1_pw_cleared", 32'(o_password), 32'd0);

        // 2: incorrect with trials left, then with trials exhausted -> lockout
        clear_counts();
        press(4'h6); press(4'h6); press(4'h6);
        enter(); tick();
        i_incorrect = 1'b1; i_trials = 2'd2; tick(); i_incorrect = 1'b0; i_trials = 2'd0;
        chk("t2_state_idle", 32'(o_state), 32'd0);
        chk("t2_cnt", 32'(o_digit_cnt), 32'd0);
        chk("t2_no_unlock", 32'(o_unlock), 32'd0);
        press(4'h6); press(4'h6); press(4'h6);
        enter(); tick();
        i_incorrect = 1'b1; i_trials = 2'd0; tick(); i_incorrect = 1'b0;
        chk("t2_lockout", 32'(o_state), 32'd5);
        chk("t2_lockout_busy", 32'(o_busy), 32'd1);
        press(4'h1);
        i_key_clear = 1'b1; tick(); i_key_clear = 1'b0;
        enter();
        chk("t2_lockout_keys_ignored", 32'(o_state), 32'd5);
        chk("t2_lockout_cnt", 32'(o_digit_cnt), 32'd0);
        chk("t2_lockout_no_err", 32'(n_err), 32'd0);
        repeat (16) tick();
        chk("t2_lockout_last_cycle", 32'(o_state), 32'd5);
        tick();
        chk("t2_lockout_end", 32'(o_state), 32'd0);
        chk("t2_lockout_len", 32'(n_lock), 32'(LOCK_T));
        chk("t2_never_unlock", 32'(n_unl), 32'd0);

        // 3: short entry -> error; overflow digits are dropped
        clear_counts();
        press(4'hC); press(4'hE);
        enter();
        chk("t3_error", 32'(o_error), 32'd1);
        chk("t3_no_confirm", 32'(o_confirm), 32'd0);
        chk("t3_state", 32'(o_state), 32'd0);
        chk("t3_buf_zero", 32'(o_password), 32'd0);
        chk("t3_cnt_zero", 32'(o_digit_cnt), 32'd0);
        tick();
        chk("t3_error_one_cycle", 32'(o_error), 32'd0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("t3_pw_123", 32'(o_password), 32'h123);
        chk("t3_cnt_sat", 32'(o_digit_cnt), 32'd3);

        // 4: verdict timeout, then entry timeout
        clear_counts();
        enter();
        chk("t4_confirm", 32'(o_confirm), 32'd1);
        for (int i = 0; i < 10 && n_err == 0; i++) tick();
        chk("t4_err_delay", 32'(err_cyc - conf_cyc), 32'(RESP_T));
        chk("t4_err_count", 32'(n_err), 32'd1);
        chk("t4_state_idle", 32'(o_state), 32'd0);
        chk("t4_cnt_zero", 32'(o_digit_cnt), 32'd0);
        press(4'h7);
        repeat (ENTRY_T - 1) tick();
        chk("t4_entry_alive", 32'(o_state), 32'd1);
        chk("t4_entry_cnt", 32'(o_digit_cnt), 32'd1);
        tick();
        chk("t4_entry_timeout", 32'(o_state), 32'd0);
        chk("t4_entry_cnt0", 32'(o_digit_cnt), 32'd0);
        chk("t4_entry_buf0", 32'(o_password), 32'd0);
        chk("t4_entry_no_err", 32'(n_err), 32'd1);

        // 5: clear beats enter; clear cuts unlock short
        clear_counts();
        press(4'h1); press(4'h2); press(4'h3);
        i_key_clear = 1'b1; i_key_enter = 1'b1; tick(); i_key_clear = 1'b0; i_key_enter = 1'b0;
        chk("t5_state", 32'(o_state), 32'd0);
        chk("t5_buf0", 32'(o_password), 32'd0);
        chk("t5_cnt0", 32'(o_digit_cnt), 32'd0);
        tick();
        chk("t5_no_confirm", 32'(n_conf), 32'd0);
        chk("t5_no_error", 32'(n_err), 32'd0);
        press(4'h4); press(4'h5); press(4'h6);
        enter(); tick();
        i_correct = 1'b1; tick(); i_correct = 1'b0;
        chk("t5_unlock", 32'(o_unlock), 32'd1);
        tick();
        i_key_clear = 1'b1; tick(); i_key_clear = 1'b0;
        chk("t5_unlock_dropped", 32'(o_unlock), 32'd0);
        chk("t5_state_idle", 32'(o_state), 32'd0);
        chk("t5_unlock_len", 32'(n_unl), 32'd2);

        // 6: asynchronous reset mid-WAIT_RESP and mid-UNLOCKED
        press(4'h7); press(4'h8); press(4'h9);
        enter(); tick();
        chk("t6_wait", 32'(o_state), 32'd3);
        i_reset_n = 1'b0; #1;
        chk_all_zero("t6_reset_wait");
        tick(); i_reset_n = 1'b1;
        press(4'h7); press(4'h8); press(4'h9);
        enter(); tick();
        i_correct = 1'b1; tick(); i_correct = 1'b0;
        chk("t6_unlocked", 32'(o_unlock), 32'd1);
        i_reset_n = 1'b0; #1;
        chk("t6_unlock_async_drop", 32'(o_unlock), 32'd0);
        chk_all_zero("t6_reset_unlocked");
        tick(); i_reset_n = 1'b1;
        tick();

        // Random transactions against a transaction-level model
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 5);
            for (int j = 0; j < 5; j++) d[j] = 0;
            for (int j = 0; j < k; j++) begin
                d[j] = $urandom_range(0, 15);
                press(4'(d[j]));
                repeat ($urandom_range(0, 3)) tick();
            end
            clear_counts();
            exp_conf = (k >= DIGITS) ? 1 : 0;
            exp_pw   = exp_conf ? (d[0] * 256 + d[1] * 16 + d[2]) : 0;
            exp_err  = 0; exp_unl = 0; exp_lock = 0;
            enter();
            if (exp_conf == 0) begin
                exp_err = 1;
            end else begin
                v  = $urandom_range(0, 3);
                dl = $urandom_range(0, RESP_T - 1);
                t  = $urandom_range(0, 3);
                repeat (dl) tick();
                i_correct   = (v == 0 || v == 2);
                i_incorrect = (v == 1 || v == 2);
                i_trials    = 2'(t);
                tick();
                i_correct = 1'b0; i_incorrect = 1'b0; i_trials = 2'd0;
                // A verdict during the confirm cycle itself is not listened to.
                if (dl == 0 || v == 3)  exp_err  = 1;
                else if (v == 0)        exp_unl  = UNLOCK_T;
                else if (t == 0)        exp_lock = LOCK_T;
            end
            repeat (40) tick();
            chk("rnd_confirms", 32'(n_conf), 32'(exp_conf));
            if (exp_conf != 0) chk("rnd_password", 32'(pw_at_conf), 32'(exp_pw));
            chk("rnd_errors", 32'(n_err), 32'(exp_err));
            chk("rnd_unlock_cycles", 32'(n_unl), 32'(exp_unl));
            chk("rnd_lockout_cycles", 32'(n_lock), 32'(exp_lock));
            chk("rnd_final_state", 32'(o_state), 32'd0);
            chk("rnd_final_cnt", 32'(o_digit_cnt), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
